// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and types for the memory stage
package mem_stage_pkg;

   localparam int WORD = 16;

   localparam logic IDLE = 1'b0;
   localparam logic WAIT = 1'b1;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_RD   = 2'd1,
      OP_WR   = 2'd2
   } mem_op_e;

   function automatic mem_op_e op_of(input logic rd, input logic wr);
      if (rd && !wr)
         return OP_RD;
      else if (wr && !rd)
         return OP_WR;
      else
         return OP_NONE;
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load enable and bubble insert
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            bubble,
   input  logic            d_valid,
   input  logic [WORD-1:0] d_rdata,
   input  logic [WORD-1:0] d_aluout,
   input  logic            d_err,
   output logic            wb_valid,
   output logic [WORD-1:0] wb_rdata,
   output logic [WORD-1:0] wb_aluout,
   output logic            err
);

   always_ff @(posedge clk) begin
      if (rst || (en && bubble)) begin
         wb_valid  <= 1'b0;
         wb_rdata  <= '0;
         wb_aluout <= '0;
         err       <= 1'b0;
      end else if (en) begin
         wb_valid  <= d_valid;
         wb_rdata  <= d_rdata;
         wb_aluout <= d_aluout;
         err       <= d_err;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: issues loads/stores to a multi-cycle
// data memory, stalls until mem_done or timeout, and feeds the MEM/WB register
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT   = 64,
   parameter int ALIGN_CHK = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [WORD-1:0] ALUOut,
   input  logic [WORD-1:0] ReadData2,
   input  logic            MemRead,
   input  logic            MemWrite,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   output logic            mem_rd,
   output logic            mem_wr,
   input  logic [WORD-1:0] mem_rdata,
   input  logic            mem_done,
   output logic            stall,
   output logic            wb_valid,
   output logic [WORD-1:0] wb_rdata,
   output logic [WORD-1:0] wb_aluout,
   output logic            err
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic ALIGN_ON = (ALIGN_CHK != 0);

   logic            state;
   logic [CW-1:0]   cnt;
   logic [WORD-1:0] lat_addr;
   logic [WORD-1:0] lat_wdata;
   mem_op_e         lat_op;

   logic            acc;
   logic            bad;
   logic            issue;
   logic            timeout_hit;

   logic            d_valid;
   logic [WORD-1:0] d_rdata;
   logic [WORD-1:0] d_aluout;
   logic            d_err;

   assign acc   = in_valid & (MemRead ^ MemWrite);
   assign bad   = in_valid & ((MemRead & MemWrite) |
                              (ALIGN_ON & (MemRead | MemWrite) & ALUOut[0]));
   assign issue = acc & ~bad;

   // A done arriving on the last allowed wait cycle still wins over the abort.
   assign timeout_hit = (state == WAIT) && !mem_done && (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      stall     = 1'b0;
      d_valid   = in_valid;
      d_aluout  = ALUOut;
      d_rdata   = '0;
      d_err     = bad;
      if (state == IDLE) begin
         if (issue) begin
            mem_addr  = ALUOut;
            mem_wdata = ReadData2;
            mem_rd    = MemRead;
            mem_wr    = MemWrite;
            stall     = ~mem_done;
            if (MemRead && mem_done)
               d_rdata = mem_rdata;
         end
      end else begin
         mem_addr  = lat_addr;
         mem_wdata = lat_wdata;
         mem_rd    = (lat_op == OP_RD);
         mem_wr    = (lat_op == OP_WR);
         stall     = ~mem_done & ~timeout_hit;
         d_valid   = 1'b1;
         d_aluout  = lat_addr;
         d_err     = timeout_hit;
         if (mem_done && lat_op == OP_RD)
            d_rdata = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_op    <= OP_NONE;
      end else if (state == IDLE) begin
         cnt <= '0;
         if (issue && !mem_done) begin
            state     <= WAIT;
            lat_addr  <= ALUOut;
            lat_wdata <= ReadData2;
            lat_op    <= op_of(MemRead, MemWrite);
         end
      end else begin
         if (mem_done || timeout_hit) begin
            state  <= IDLE;
            cnt    <= '0;
            lat_op <= OP_NONE;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Nothing downstream of MEM/WB can stall, so the register loads every edge.
   mem_wb_reg u_mem_wb_reg (
      .clk       (clk),
      .rst       (rst),
      .en        (1'b1),
      .bubble    (stall),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .d_aluout  (d_aluout),
      .d_err     (d_err),
      .wb_valid  (wb_valid),
      .wb_rdata  (wb_rdata),
      .wb_aluout (wb_aluout),
      .err       (err)
   );

endmodule
